dma_stream_realigner: RTL and testbench

//  Parametrised successor of the DMA shift aligner. Re-aligns a multi-beat read burst from a source byte offset
//  to a destination byte offset and emits write beats with per-byte strobes.

---
 rtl/dma_stream_realigner.sv | 217 +++++++++++++++++++++
 tb/tb_dma_stream_realigner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_realigner.sv
// Re-aligns a multi-beat read burst from a source byte offset to a destination byte offset, emitting strobed write beats.
// Optional build macro DMA_REALIGN_ZERO_FILL_EN: drive 0x00 on every byte whose wr_strb bit is 0.
module dma_stream_realigner #(
  parameter int DATA_W = 512,
  parameter int OFFS_W = $clog2(DATA_W / 8),
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OFFS_W-1:0]     src_head,
  input  logic [OFFS_W-1:0]     src_tail,
  input  logic [LEN_W-1:0]      src_alen,
  input  logic [OFFS_W-1:0]     dst_head,
  input  logic [OFFS_W-1:0]     dst_tail,
  input  logic [LEN_W-1:0]      dst_alen,
  output logic                  cmd_err,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_last,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;
  localparam int CW = LEN_W + OFFS_W + 1;
  localparam int BW = LEN_W + 1;

  // Handshake rule for all three channels: a transfer happens on a rising clk edge where valid && ready;
  // a producer holding valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  src_alen_q, src_alen_d;
  logic [LEN_W-1:0]  dst_alen_q, dst_alen_d;
  logic [OFFS_W-1:0] dst_head_q, dst_head_d;
  logic [OFFS_W-1:0] dst_tail_q, dst_tail_d;
  logic [OFFS_W-1:0] shift_q, shift_d;
  logic              lead_q, lead_d;
  logic [BW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [BW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              wr_valid_q, wr_valid_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NB-1:0]     wr_strb_q, wr_strb_d;
  logic              wr_last_q, wr_last_d;
  logic              cmd_err_q, cmd_err_d;

  logic signed [CW-1:0] src_m1, dst_m1;
  logic                 cmd_good;
  logic                 slot_free, rd_ready_c, rd_fire, all_rd_q;
  logic                 wr_more, produce, first_beat, last_beat;
  logic                 all_rd_d, all_wr_d;
  logic [BW-1:0]        src_alen_ext, dst_alen_ext;
  logic [DATA_W-1:0]    cur_beat, beat_data;
  logic [OFFS_W:0]      nsh;
  logic [NB-1:0]        head_mask, tail_mask, beat_strb;
`ifdef DMA_REALIGN_ZERO_FILL_EN
  logic [DATA_W-1:0]    byte_mask;
`endif

  // Byte count minus one: alen*NB + tail - head; avoids overflow at the largest legal burst.
  assign src_m1   = $signed({1'b0, src_alen, src_tail}) - $signed({{(LEN_W + 1){1'b0}}, src_head});
  assign dst_m1   = $signed({1'b0, dst_alen, dst_tail}) - $signed({{(LEN_W + 1){1'b0}}, dst_head});
  assign cmd_good = (src_m1 == dst_m1) && !src_m1[CW-1];

  assign src_alen_ext = {1'b0, src_alen_q};
  assign dst_alen_ext = {1'b0, dst_alen_q};
  assign all_rd_q     = rd_cnt_q > src_alen_ext;
  assign slot_free    = !wr_valid_q || wr_ready;
  assign rd_ready_c   = !rst && (state_q == RUN) && slot_free && !all_rd_q;
  assign rd_fire      = rd_valid && rd_ready_c;
  assign wr_more      = wr_cnt_q <= dst_alen_ext;
  assign first_beat   = wr_cnt_q == '0;
  assign last_beat    = wr_cnt_q == dst_alen_ext;

  assign cmd_ready = !rst && (state_q == IDLE);
  assign rd_ready  = rd_ready_c;
  assign cmd_err   = cmd_err_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign wr_strb   = wr_strb_q;
  assign wr_last   = wr_last_q;
  assign busy      = state_q != IDLE;

  always_comb begin
    state_d    = state_q;
    src_alen_d = src_alen_q;
    dst_alen_d = dst_alen_q;
    dst_head_d = dst_head_q;
    dst_tail_d = dst_tail_q;
    shift_d    = shift_q;
    lead_d     = lead_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    res_d      = res_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    wr_last_d  = wr_last_q;
    cmd_err_d  = 1'b0;
    produce    = 1'b0;
    cur_beat   = rd_data;
    all_rd_d   = 1'b0;
    all_wr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_good) begin
            state_d    = RUN;
            src_alen_d = src_alen;
            dst_alen_d = dst_alen;
            dst_head_d = dst_head;
            dst_tail_d = dst_tail;
            shift_d    = dst_head - src_head;
            lead_d     = dst_head < src_head;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            res_d      = '0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + BW'(1);
          res_d    = rd_data;
          // With a leading source beat the first read only primes the residue.
          produce  = wr_more && (!lead_q || (rd_cnt_q != '0));
        end
      end
      FLUSH: begin
        if (slot_free && wr_more) begin
          produce  = 1'b1;
          cur_beat = '0;
          res_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output byte j takes byte (j + NB - shift) of the {current, residue} pair.
    nsh       = (OFFS_W + 1)'(NB) - {1'b0, shift_q};
    beat_data = DATA_W'({cur_beat, res_q} >> {nsh, 3'b000});
    head_mask = {NB{1'b1}} << dst_head_q;
    tail_mask = {NB{1'b1}} >> (OFFS_W'(NB - 1) - dst_tail_q);
    beat_strb = (first_beat ? head_mask : {NB{1'b1}}) & (last_beat ? tail_mask : {NB{1'b1}});
`ifdef DMA_REALIGN_ZERO_FILL_EN
    for (int j = 0; j < NB; j++) begin
      byte_mask[j*8 +: 8] = {8{beat_strb[j]}};
    end
    beat_data = beat_data & byte_mask;
`endif

    if (slot_free) begin
      wr_valid_d = produce;
      if (produce) begin
        wr_data_d = beat_data;
        wr_strb_d = beat_strb;
        wr_last_d = last_beat;
        wr_cnt_d  = wr_cnt_q + BW'(1);
      end
    end

    if (state_q != IDLE) begin
      all_rd_d = rd_cnt_d > src_alen_ext;
      all_wr_d = wr_cnt_d > dst_alen_ext;
      if (!all_rd_d)      state_d = RUN;
      else if (!all_wr_d) state_d = FLUSH;
      else if (!wr_valid_d) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_alen_q <= '0;
      dst_alen_q <= '0;
      dst_head_q <= '0;
      dst_tail_q <= '0;
      shift_q    <= '0;
      lead_q     <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      res_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_last_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_alen_q <= src_alen_d;
      dst_alen_q <= dst_alen_d;
      dst_head_q <= dst_head_d;
      dst_tail_q <= dst_tail_d;
      shift_q    <= shift_d;
      lead_q     <= lead_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      res_q      <= res_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_last_q  <= wr_last_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_dma_stream_realigner.sv
// Directed bench for dma_stream_realigner: byte-level reference model feeding an expected-beat queue.
module tb_dma_stream_realigner;
  localparam int DATA_W = 512;
  localparam int NB     = DATA_W / 8;
  localparam int OFFS_W = 6;
  localparam int LEN_W  = 8;
  localparam int MAXB   = 8;
  localparam int BUDGET = 200;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready, cmd_err;
  logic [OFFS_W-1:0] src_head, src_tail, dst_head, dst_tail;
  logic [LEN_W-1:0]  src_alen, dst_alen;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid, wr_ready, wr_last, busy;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     strb;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] rd_beats [MAXB];
  int                checks = 0;
  int                errors = 0;

  dma_stream_realigner #(.DATA_W(DATA_W), .OFFS_W(OFFS_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .src_head(src_head), .src_tail(src_tail), .src_alen(src_alen),
    .dst_head(dst_head), .dst_tail(dst_tail), .dst_alen(dst_alen),
    .cmd_err(cmd_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_last(wr_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] bmask(input logic [NB-1:0] s);
    logic [DATA_W-1:0] m;
    for (int j = 0; j < NB; j++) m[j*8 +: 8] = {8{s[j]}};
    return m;
  endfunction

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++)
      for (int w = 0; w < DATA_W / 32; w++) rd_beats[b][w*32 +: 32] = $urandom;
  endtask

  // Reference: destination byte j of beat k carries stream byte D = k*NB + j - dst_head.
  task automatic model(input int sh, input int dh, input int dt, input int da);
    int nbytes, d, p;
    beat_t b;
    logic [DATA_W-1:0] src;
    nbytes = da * NB + dt - dh + 1;
    for (int k = 0; k <= da; k++) begin
      b = '0;
      for (int j = 0; j < NB; j++) begin
        d = k * NB + j - dh;
        if (d >= 0 && d < nbytes) begin
          p = d + sh;
          src = rd_beats[p / NB];
          b.strb[j] = 1'b1;
          b.data[j*8 +: 8] = src[(p % NB)*8 +: 8];
        end
      end
      b.last = (k == da);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input int sh, input int st, input int sa, input int dh, input int dt, input int da);
    @(negedge clk);
    src_head = OFFS_W'(sh);
    src_tail = OFFS_W'(st);
    src_alen = LEN_W'(sa);
    dst_head = OFFS_W'(dh);
    dst_tail = OFFS_W'(dt);
    dst_alen = LEN_W'(da);
    cmd_valid = 1'b1;
    #1;
    chk_bit("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: sink always ready; 1: ready 1,0,1,0...; 2: random ready.
  task automatic run_data(input string tag, input int n_rd, input int mode);
    int rd_idx = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    logic [NB-1:0] p_strb = '0;
    logic p_last = 1'b0;
    beat_t e;
    while ((exp_q.size() > 0 || rd_idx < n_rd) && cyc < BUDGET) begin
      @(negedge clk);
      rd_valid = rd_idx < n_rd;
      rd_data  = (rd_idx < n_rd) ? rd_beats[rd_idx] : '0;
      case (mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (cyc % 2) == 0;
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        chk_bit({tag, "_hold_valid"}, wr_valid, 1'b1);
        chk_vec({tag, "_hold_data"}, wr_data, p_data);
        chk_vec({tag, "_hold_strb"}, DATA_W'(wr_strb), DATA_W'(p_strb));
        chk_bit({tag, "_hold_last"}, wr_last, p_last);
      end
      if (wr_valid && !wr_ready) chk_bit({tag, "_rd_ready_stall"}, rd_ready, 1'b0);
      if (rd_idx >= n_rd) chk_bit({tag, "_rd_ready_done"}, rd_ready, 1'b0);
      if (exp_q.size() == 0) begin
        chk_bit({tag, "_extra_wr"}, wr_valid, 1'b0);
      end else if (wr_valid && wr_ready) begin
        e = exp_q.pop_front();
`ifdef DMA_REALIGN_ZERO_FILL_EN
        chk_vec({tag, "_data"}, wr_data, e.data);
`else
        chk_vec({tag, "_data"}, wr_data & bmask(e.strb), e.data);
`endif
        chk_vec({tag, "_strb"}, DATA_W'(wr_strb), DATA_W'(e.strb));
        chk_bit({tag, "_last"}, wr_last, e.last);
      end
      if (rd_valid && rd_ready) rd_idx++;
      stalled = wr_valid && !wr_ready;
      p_data  = wr_data;
      p_strb  = wr_strb;
      p_last  = wr_last;
      @(posedge clk);
      cyc++;
    end
    chk_bit({tag, "_complete"}, (exp_q.size() == 0) && (rd_idx == n_rd), 1'b1);
    exp_q.delete();
    @(negedge clk);
    rd_valid = 1'b0;
    wr_ready = 1'b1;
    #1;
    chk_bit({tag, "_busy_end"}, busy, 1'b0);
    chk_bit({tag, "_wr_valid_end"}, wr_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk_vec({tag, "_ctrl"}, DATA_W'({cmd_ready, cmd_err, rd_ready, wr_valid, wr_last, busy}), '0);
    chk_vec({tag, "_strb"}, DATA_W'(wr_strb), '0);
    chk_vec({tag, "_data"}, wr_data, '0);
  endtask

  task automatic load_case2_beats();
    logic [DATA_W-1:0] v;
    v = {128{4'hF}}; rd_beats[0] = v;
    v = {128{4'hE}}; rd_beats[1] = v;
    v = {128{4'h8}}; rd_beats[2] = v;
    v = {128{4'h3}}; rd_beats[3] = v;
  endtask

  initial begin
    int sh, st, sa, dh, nb, dend;
    rst = 1'b1;
    cmd_valid = 1'b0;
    src_head = '0; src_tail = '0; src_alen = '0;
    dst_head = '0; dst_tail = '0; dst_alen = '0;
    rd_valid = 1'b0; rd_data = '0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Case 1: straight pass-through of one full beat.
    fill_random(1);
    model(0, 0, 63, 0);
    send_cmd(0, 63, 0, 0, 63, 0);
    chk_bit("c1_busy", busy, 1'b1);
    run_data("c1", 1, 0);

    // Case 2: head 3 -> 13 over four beats.
    load_case2_beats();
    model(3, 13, 17, 3);
    send_cmd(3, 7, 3, 13, 17, 3);
    run_data("c2", 4, 0);

    // Case 3: two read beats collapse into one write beat.
    fill_random(2);
    model(40, 0, 34, 0);
    send_cmd(40, 10, 1, 0, 34, 0);
    run_data("c3", 2, 0);

    // Case 4: one read beat expands to two write beats, second from residue.
    fill_random(1);
    model(0, 32, 31, 1);
    send_cmd(0, 63, 0, 32, 31, 1);
    run_data("c4", 1, 0);

    // Case 5: case 2 with an alternating sink.
    load_case2_beats();
    model(3, 13, 17, 3);
    send_cmd(3, 7, 3, 13, 17, 3);
    run_data("c5", 4, 1);

    // Case 6a: mismatched byte counts are rejected.
    send_cmd(0, 9, 0, 0, 10, 0);
    chk_bit("c6_err_pulse", cmd_err, 1'b1);
    chk_bit("c6_err_busy", busy, 1'b0);
    @(negedge clk);
    rd_valid = 1'b1;
    #1;
    chk_bit("c6_err_rd_ready", rd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("c6_err_clear", cmd_err, 1'b0);
    chk_bit("c6_err_rd_ready2", rd_ready, 1'b0);
    chk_bit("c6_err_cmd_ready", cmd_ready, 1'b1);
    rd_valid = 1'b0;

    // Case 6b: reset in the middle of a burst.
    load_case2_beats();
    send_cmd(3, 7, 3, 13, 17, 3);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = rd_beats[0];
    wr_ready = 1'b0;
    @(negedge clk);
    rd_data = rd_beats[1];
    #1;
    chk_bit("c6_mid_busy", busy, 1'b1);
    chk_bit("c6_mid_wr_valid", wr_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("c6_rst");
    @(negedge clk);
    rst = 1'b0;
    rd_valid = 1'b0;
    wr_ready = 1'b1;
    #1;
    chk_bit("c6_post_rst_cmd_ready", cmd_ready, 1'b1);
    fill_random(1);
    model(0, 0, 63, 0);
    send_cmd(0, 63, 0, 0, 63, 0);
    run_data("c6_clean", 1, 0);

    // Random legal geometries with a random sink.
    for (int t = 0; t < 6; t++) begin
      sh = $urandom_range(0, NB - 1);
      sa = $urandom_range(0, 3);
      st = (sa == 0) ? $urandom_range(sh, NB - 1) : $urandom_range(0, NB - 1);
      nb = sa * NB + st - sh + 1;
      dh = $urandom_range(0, NB - 1);
      dend = dh + nb - 1;
      fill_random(sa + 1);
      model(sh, dh, dend % NB, dend / NB);
      send_cmd(sh, st, sa, dh, dend % NB, dend / NB);
      run_data("rnd", sa + 1, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
